multi_peak_detector: RTL and testbench

Generalised successor to the two-filter peak detector feeding the waterfall RAM manager. It tracks per-window peaks on NUM_CH parallel sample streams, such as filter bank outputs. Three selectable modes are supported: signed max, absolute max, and peak-to-peak. Each window result is presented on a valid/ready output with single-entry holding and sticky overflow. It runs on the 20 MHz sample clock, between the FIR filters and ram_manager.

---
 rtl/multi_peak_detector.sv | 119 +++++++++++
 tb/tb_multi_peak_detector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multi_peak_detector.sv
// Per-window peak tracker on NUM_CH parallel streams: signed max, abs max or peak-to-peak.
// Latency: result registered 1 clk after the in_valid that completes a WINDOW-sample window.
// Backpressure: input is never stalled; an unaccepted result is overwritten and sets sticky overflow.
// Ports: clk/reset_n (async active-low), clear (sync abort), mode, in_data/in_valid (packed samples),
//        out_data/out_valid/out_ready (packed results, single holding register), overflow, sample_count.
module multi_peak_detector #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 12,
   parameter int WINDOW = 1024,
   parameter int CNT_W  = 10
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           clear,
   input  logic [1:0]                     mode,
   input  logic [NUM_CH*DATA_W-1:0]       in_data,
   input  logic                           in_valid,
   output logic [NUM_CH*(DATA_W+1)-1:0]   out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overflow,
   output logic [CNT_W-1:0]               sample_count
);

   localparam int              RW     = DATA_W + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WINDOW - 1);
   localparam logic [1:0]      M_SMAX = 2'b00;
   localparam logic [1:0]      M_AMAX = 2'b01;
   localparam logic [1:0]      M_P2P  = 2'b10;

   typedef logic signed [RW-1:0] trk_t;

   // Trackers are one bit wider than a sample so |-2^(DATA_W-1)| fits and
   // abs-mode values stay non-negative under the signed compare.
   trk_t max_q  [NUM_CH];
   trk_t min_q  [NUM_CH];
   trk_t max_nx [NUM_CH];
   trk_t min_nx [NUM_CH];
   trk_t s_ext  [NUM_CH];
   trk_t s_val  [NUM_CH];

   logic [1:0]           mode_q;
   logic [1:0]           mode_in;
   logic [1:0]           mode_eff;
   logic                 first;
   logic                 take;
   logic                 done;
   logic [NUM_CH*RW-1:0] res;

   // Mode 11 behaves as absolute max.
   assign mode_in  = (mode == 2'b11) ? M_AMAX : mode;
   assign first    = (sample_count == '0);
   // The first sample of a window uses the incoming mode; later ones use the latched one.
   assign mode_eff = first ? mode_in : mode_q;
   assign take     = in_valid & ~clear;
   assign done     = take & (sample_count == LAST);

   always_comb begin
      res = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         s_ext[k]  = {in_data[k*DATA_W + DATA_W - 1], in_data[k*DATA_W +: DATA_W]};
         s_val[k]  = (mode_eff == M_AMAX && s_ext[k][RW-1]) ? -s_ext[k] : s_ext[k];
         if (first) begin
            max_nx[k] = s_val[k];
            min_nx[k] = s_val[k];
         end else begin
            max_nx[k] = (s_val[k] > max_q[k]) ? s_val[k] : max_q[k];
            min_nx[k] = (s_val[k] < min_q[k]) ? s_val[k] : min_q[k];
         end
         // Signed max is already sign-extended and abs max already non-negative,
         // so both report the max tracker directly.
         res[k*RW +: RW] = (mode_eff == M_P2P) ? (max_nx[k] - min_nx[k]) : max_nx[k];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_count <= '0;
         mode_q       <= M_SMAX;
         out_data     <= '0;
         out_valid    <= 1'b0;
         overflow     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            max_q[k] <= '0;
            min_q[k] <= '0;
         end
      end else if (clear) begin
         sample_count <= '0;
         out_valid    <= 1'b0;
         overflow     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            max_q[k] <= '0;
            min_q[k] <= '0;
         end
      end else begin
         if (take) begin
            for (int k = 0; k < NUM_CH; k++) begin
               max_q[k] <= max_nx[k];
               min_q[k] <= min_nx[k];
            end
            if (first) begin
               mode_q <= mode_in;
            end
            sample_count <= done ? '0 : sample_count + 1'b1;
         end
         if (done) begin
            out_data  <= res;
            out_valid <= 1'b1;
            // Same-cycle acceptance frees the holding register, so no overflow then.
            if (out_valid && !out_ready) begin
               overflow <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multi_peak_detector.sv
module tb_multi_peak_detector;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear;
   logic [1:0]  mode;
   logic [23:0] in_data;
   logic        in_valid;
   logic [25:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        overflow;
   logic [1:0]  sample_count;

   int errors = 0;
   int checks = 0;
   logic [25:0] exp_q [$];

   multi_peak_detector #(.NUM_CH(2), .DATA_W(12), .WINDOW(4), .CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
      .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   function automatic logic [25:0] pack(input int r0, input int r1);
      return {13'(r1), 13'(r0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One sample per clock; back-to-back calls give continuous in_valid.
   task automatic smp(input int a, input int b);
      in_data  = {12'(b), 12'(a)};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted result must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected: got %0h with no expected result", out_data);
         end else begin
            logic [25:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL result_data: got %0h expected %0h", out_data, e);
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; mode = 2'b00;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_count", 32'(sample_count), 0);
      chk("rst_out_data", 32'(out_data), 0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);

      // Signed max, 1-clk latency.
      mode = 2'b00;
      exp_q.push_back(pack(37, 13'h1FFF));
      smp(5, -3); smp(-100, -7); smp(37, -1);
      chk("t1_count3", 32'(sample_count), 3);
      chk("t1_not_valid_early", 32'(out_valid), 0);
      smp(2, -9);
      chk("t1_valid_latency", 32'(out_valid), 1);
      chk("t1_count_wrap", 32'(sample_count), 0);

      // Absolute max incl. most-negative sample.
      mode = 2'b01;
      exp_q.push_back(pack(2048, 300));
      smp(-2048, 100); smp(10, -300); smp(0, 200); smp(5, 0);

      // Peak-to-peak at full range and constant input.
      mode = 2'b10;
      exp_q.push_back(pack(4095, 0));
      smp(-2048, 7); smp(2047, 7); smp(0, 7); smp(0, 7);
      idle(2);

      // Overwrite of an unaccepted result.
      mode = 2'b00;
      out_ready = 1'b0;
      smp(50, 0); smp(1, 0); smp(2, 0); smp(3, 0);
      chk("t4_valid_a", 32'(out_valid), 1);
      chk("t4_data_a", 32'(out_data), 32'(pack(50, 0)));
      chk("t4_no_ovf_a", 32'(overflow), 0);
      smp(60, 0); smp(1, 0); smp(2, 0); smp(3, 0);
      chk("t4_valid_b", 32'(out_valid), 1);
      chk("t4_data_b", 32'(out_data), 32'(pack(60, 0)));
      chk("t4_ovf_set", 32'(overflow), 1);
      exp_q.push_back(pack(60, 0));
      out_ready = 1'b1;
      idle(1);
      chk("t4_valid_drop", 32'(out_valid), 0);
      chk("t4_ovf_sticky", 32'(overflow), 1);

      // Mode change mid-window applies to the next window only.
      exp_q.push_back(pack(8, 3));
      smp(-5, 3); smp(8, -4);
      mode = 2'b10;
      smp(1, -20); smp(0, 0);
      exp_q.push_back(pack(20, 0));
      smp(10, -1); smp(-10, -1); smp(0, -1); smp(0, -1);
      idle(2);

      // Clear with three samples accumulated and a sample in the clear cycle.
      smp(900, 900); smp(-900, -900); smp(5, 5);
      chk("t6_count_pre", 32'(sample_count), 3);
      chk("t6_ovf_pre", 32'(overflow), 1);
      clear = 1'b1;
      smp(1000, 1000);
      clear = 1'b0;
      chk("t6_clr_count", 32'(sample_count), 0);
      chk("t6_clr_valid", 32'(out_valid), 0);
      chk("t6_clr_ovf", 32'(overflow), 0);
      out_ready = 1'b0;
      smp(1, -8); smp(2, 8); smp(3, 0); smp(4, 0);
      chk("t6_win_valid", 32'(out_valid), 1);
      chk("t6_win_data", 32'(out_data), 32'(pack(3, 16)));
      smp(11, 11); smp(12, 12);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_arst_valid", 32'(out_valid), 0);
      chk("t6_arst_data", 32'(out_data), 0);
      chk("t6_arst_count", 32'(sample_count), 0);
      chk("t6_arst_ovf", 32'(overflow), 0);
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      idle(1);
      mode = 2'b00;
      exp_q.push_back(pack(13'h1FFF, 9));
      smp(-1, 9); smp(-2, 0); smp(-3, 0); smp(-4, 0);
      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
